// File: rtl/xd_mul.sv
// xd_mul: skip-connection term xD[b,h,p] = D[h] * x[b,h,p] in FP16.
// PAR_H multiplier lanes sweep the B*H*P tensor; done is sticky so a
// downstream adder can AND it with its other producer's completion.
//
// fp16_mul_wrapper: IEEE FP16 multiply, round-to-nearest-even, with
// subnormal inputs/outputs, overflow to infinity and a canonical quiet NaN.
// The product is formed combinationally and then delayed through LAT
// registers, so valid_in -> valid_out is exactly LAT cycles.

module fp16_mul_wrapper #(
    parameter int LAT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        valid_out,
    output logic [15:0] result
);

    logic        v_pipe [LAT];
    logic [15:0] r_pipe [LAT];
    logic [15:0] res_c;

    // Combinational FP16 product with RNE rounding.
    always_comb begin
        logic        sign;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [10:0] sig_a, sig_b;
        logic [21:0] prod;
        logic [47:0] wide, shifted, back;
        logic        guard, sticky;
        logic [11:0] n;
        logic [4:0]  ef_bits;
        int          exp_a, exp_b, msb, e_biased, e_eff, rsh, ef;

        res_c    = '0;
        sign     = a[15] ^ b[15];
        a_nan    = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
        b_nan    = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
        a_inf    = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        b_inf    = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        a_zero   = (a[14:0] == 15'h0);
        b_zero   = (b[14:0] == 15'h0);
        sig_a    = {(a[14:10] != 5'h0), a[9:0]};
        sig_b    = {(b[14:10] != 5'h0), b[9:0]};
        exp_a    = (a[14:10] == 5'h0) ? 1 : int'(a[14:10]);
        exp_b    = (b[14:10] == 5'h0) ? 1 : int'(b[14:10]);
        prod     = sig_a * sig_b;
        msb      = 0;
        e_biased = 0;
        e_eff    = 0;
        rsh      = 0;
        ef       = 0;
        ef_bits  = '0;
        wide     = '0;
        shifted  = '0;
        back     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        n        = '0;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res_c = 16'h7E00;
        end else if (a_inf || b_inf) begin
            res_c = {sign, 5'h1F, 10'h0};
        end else if (prod == 22'h0) begin
            res_c = {sign, 15'h0};
        end else begin
            for (int k = 0; k < 22; k++) begin
                if (prod[k]) msb = k;
            end
            // Exponent field if the leading one becomes the hidden bit;
            // below 1 the result is subnormal and uses exponent 1 scaling.
            e_biased = msb + exp_a + exp_b - 35;
            e_eff    = (e_biased < 1) ? 1 : e_biased;
            // Right shift that leaves the 11-bit significand in bits [12:2],
            // guard in bit 1 and the first sticky bit in bit 0.
            rsh = 49 + e_eff - exp_a - exp_b;
            if (rsh > 47) rsh = 47;
            wide    = {prod, 26'h0};
            shifted = wide >> rsh;
            back    = shifted << rsh;
            guard   = shifted[1];
            sticky  = shifted[0] | (back != wide);
            n       = {1'b0, shifted[12:2]};
            if (guard && (sticky || n[0])) n = n + 12'd1;
            if (n[11]) begin
                e_eff = e_eff + 1;
                n     = 12'h400;
            end
            ef = n[10] ? e_eff : 0;
            if (ef >= 31) begin
                res_c = {sign, 5'h1F, 10'h0};
            end else begin
                ef_bits = 5'(ef);
                res_c   = {sign, ef_bits, n[9:0]};
            end
        end
    end

    // Latency pipeline for result and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                v_pipe[k] <= 1'b0;
                r_pipe[k] <= '0;
            end
        end else begin
            v_pipe[0] <= valid_in;
            r_pipe[0] <= res_c;
            for (int k = 1; k < LAT; k++) begin
                v_pipe[k] <= v_pipe[k-1];
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign valid_out = v_pipe[LAT-1];
    assign result    = r_pipe[LAT-1];

endmodule

// state | meaning
// IDLE  | waiting for start; done holds the previous run's completion
// CALC  | one issue per cycle across all lanes, p fastest, then h, then b
// FLUSH | no issues; M_LAT+1 cycles for the last products to land
// DONE  | single cycle; raises the sticky done flag
module xd_mul #(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int DW    = 16,
    parameter int M_LAT = 6,
    parameter int PAR_H = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [B*H*P*DW-1:0] x_flat,
    input  logic [H*DW-1:0]   D_flat,
    output logic [B*H*P*DW-1:0] xD_flat,
    output logic              busy,
    output logic              done
);

    localparam int NE = B * H * P;
    localparam int GW = (NE > 1) ? $clog2(NE) : 1;
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam int HW = (H > 1) ? $clog2(H) : 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int FW = $clog2(M_LAT + 2);

    typedef enum logic [1:0] {IDLE, CALC, FLUSH, DONE} state_t;

    state_t          state, state_next;
    logic [BW-1:0]   b_idx;
    logic [HW-1:0]   h_idx;
    logic [PW-1:0]   p_idx;
    logic [FW-1:0]   flush_cnt;
    logic            last_issue, flush_end, h_wrap;

    logic            iss_v [PAR_H];
    logic [GW-1:0]   iss_g [PAR_H];
    logic [DW-1:0]   iss_x [PAR_H];
    logic [DW-1:0]   iss_d [PAR_H];

    logic            op_v  [PAR_H];
    logic [GW-1:0]   op_g  [PAR_H];
    logic [DW-1:0]   op_x  [PAR_H];
    logic [DW-1:0]   op_d  [PAR_H];

    logic            tag_v [PAR_H][M_LAT];
    logic [GW-1:0]   tag_g [PAR_H][M_LAT];

    logic            mul_vout [PAR_H];
    logic [DW-1:0]   mul_res  [PAR_H];

    assign h_wrap     = (int'(h_idx) + PAR_H >= H);
    assign last_issue = (p_idx == PW'(P - 1)) && h_wrap && (b_idx == BW'(B - 1));
    assign flush_end  = (flush_cnt == FW'(M_LAT));
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_issue) state_next = FLUSH;
            FLUSH:   if (flush_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Index walk and flush timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_idx     <= '0;
            h_idx     <= '0;
            p_idx     <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        b_idx <= '0;
                        h_idx <= '0;
                        p_idx <= '0;
                    end
                end
                CALC: begin
                    if (p_idx == PW'(P - 1)) begin
                        p_idx <= '0;
                        if (h_wrap) begin
                            h_idx <= '0;
                            b_idx <= (b_idx == BW'(B - 1)) ? '0 : b_idx + 1'b1;
                        end else begin
                            h_idx <= HW'(int'(h_idx) + PAR_H);
                        end
                    end else begin
                        p_idx <= p_idx + 1'b1;
                    end
                    if (last_issue) flush_cnt <= '0;
                end
                FLUSH:   flush_cnt <= flush_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky done: cleared only by an accepted start or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        done <= 1'b0;
        else if (state == IDLE && start) done <= 1'b0;
        else if (state == DONE)          done <= 1'b1;
    end

    // Per-lane operand selection; lanes past the last head stay idle.
    always_comb begin
        int hh;
        int g;
        hh = 0;
        g  = 0;
        for (int i = 0; i < PAR_H; i++) begin
            iss_v[i] = 1'b0;
            iss_g[i] = '0;
            iss_x[i] = '0;
            iss_d[i] = '0;
            hh = int'(h_idx) + i;
            if (state == CALC && hh < H) begin
                g        = int'(b_idx) * H * P + hh * P + int'(p_idx);
                iss_v[i] = 1'b1;
                iss_g[i] = GW'(g);
                iss_x[i] = x_flat[g*DW +: DW];
                iss_d[i] = D_flat[hh*DW +: DW];
            end
        end
    end

    // Operand registers feeding the multipliers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAR_H; i++) begin
                op_v[i] <= 1'b0;
                op_g[i] <= '0;
                op_x[i] <= '0;
                op_d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PAR_H; i++) begin
                op_v[i] <= iss_v[i];
                op_g[i] <= iss_g[i];
                op_x[i] <= iss_x[i];
                op_d[i] <= iss_d[i];
            end
        end
    end

    // Destination tags travel alongside each multiplier's latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAR_H; i++) begin
                for (int k = 0; k < M_LAT; k++) begin
                    tag_v[i][k] <= 1'b0;
                    tag_g[i][k] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < PAR_H; i++) begin
                tag_v[i][0] <= op_v[i];
                tag_g[i][0] <= op_g[i];
                for (int k = 1; k < M_LAT; k++) begin
                    tag_v[i][k] <= tag_v[i][k-1];
                    tag_g[i][k] <= tag_g[i][k-1];
                end
            end
        end
    end

    for (genvar i = 0; i < PAR_H; i++) begin : g_lane
        fp16_mul_wrapper #(.LAT(M_LAT)) u_mul (
            .clk       (clk),
            .rst       (rst),
            .valid_in  (op_v[i]),
            .a         (op_d[i]),
            .b         (op_x[i]),
            .valid_out (mul_vout[i]),
            .result    (mul_res[i])
        );
    end

    // Writeback of finished products to their tagged element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xD_flat <= '0;
        end else begin
            for (int i = 0; i < PAR_H; i++) begin
                if (mul_vout[i] && tag_v[i][M_LAT-1])
                    xD_flat[int'(tag_g[i][M_LAT-1])*DW +: DW] <= mul_res[i];
            end
        end
    end

endmodule

// File: tb/tb_xd_mul.sv
// Bench for xd_mul: two configurations, FP16 reference built on real arithmetic.
module tb_xd_mul;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Configuration A: B=1, H=4, P=4, PAR_H=16
    logic         start_a = 1'b0;
    logic [255:0] x_a = '0;
    logic [63:0]  d_a = '0;
    logic [255:0] xd_a;
    logic         busy_a, done_a;

    // Configuration B: B=2, H=5, P=3, PAR_H=2
    logic         start_b = 1'b0;
    logic [479:0] x_b = '0;
    logic [79:0]  d_b = '0;
    logic [479:0] xd_b;
    logic         busy_b, done_b;

    logic [15:0] xa [16];
    logic [15:0] da [4];
    logic [15:0] xb [30];
    logic [15:0] db [5];

    int n_checks = 0;
    int n_errors = 0;

    xd_mul #(.B(1), .H(4), .P(4), .DW(16), .M_LAT(6), .PAR_H(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .x_flat(x_a), .D_flat(d_a),
        .xD_flat(xd_a), .busy(busy_a), .done(done_a)
    );

    xd_mul #(.B(2), .H(5), .P(3), .DW(16), .M_LAT(6), .PAR_H(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .x_flat(x_b), .D_flat(d_b),
        .xD_flat(xd_b), .busy(busy_b), .done(done_b)
    );

    // ---------------- reference model ----------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real f16_mag(input logic [15:0] v);
        int e = int'(v[14:10]);
        int m = int'(v[9:0]);
        if (e == 0) return m * pow2(-24);
        return (1024 + m) * pow2(e - 25);
    endfunction

    function automatic int round_even(input real q);
        int  t = $rtoi(q);
        real f = q - t;
        if (f > 0.5 || (f == 0.5 && (t % 2) == 1)) t = t + 1;
        return t;
    endfunction

    // Nearest FP16 magnitude (15 bits) for a non-negative real.
    function automatic logic [14:0] to_f16_mag(input real a);
        int e = 0;
        int n;
        if (a == 0.0) return 15'h0;
        if (a < pow2(-14)) return 15'(round_even(a * pow2(24)));
        for (int k = 1; k <= 30; k++) if (e == 0 && a < pow2(k - 14)) e = k;
        if (e == 0) return 15'h7C00;
        n = round_even(a * pow2(25 - e));
        if (n == 2048) begin e = e + 1; n = 1024; end
        if (e >= 31) return 15'h7C00;
        return {5'(e), 10'(n - 1024)};
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        return {a[15] ^ b[15], to_f16_mag(f16_mag(a) * f16_mag(b))};
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        real s = (a[15] ? -f16_mag(a) : f16_mag(a)) + (b[15] ? -f16_mag(b) : f16_mag(b));
        if (s < 0.0) return {1'b1, to_f16_mag(-s)};
        return {1'b0, to_f16_mag(s)};
    endfunction

    function automatic logic [15:0] rand_f16();
        logic [15:0] v = 16'($urandom);
        if (v[14:10] == 5'h1F) v[14] = 1'b0;
        return v;
    endfunction

    // ---------------- helpers (no checking) ----------------
    task automatic pack_a();
        for (int g = 0; g < 16; g++) x_a[g*16 +: 16] = xa[g];
        for (int h = 0; h < 4; h++)  d_a[h*16 +: 16] = da[h];
    endtask

    task automatic pack_b();
        for (int g = 0; g < 30; g++) x_b[g*16 +: 16] = xb[g];
        for (int h = 0; h < 5; h++)  d_b[h*16 +: 16] = db[h];
    endtask

    // Cycle 0 is the cycle start is presented; returns the cycle done is first seen.
    task automatic run_a(output int cyc);
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; cyc = 1;
        while (done_a !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic run_b(output int cyc);
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0; cyc = 1;
        while (done_b !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_checks++; if (xd_a !== '0)   begin n_errors++; $display("FAIL reset xd_a got %h required 0", xd_a); end
        n_checks++; if (done_a !== 1'b0) begin n_errors++; $display("FAIL reset done_a got %b required 0", done_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL reset busy_a got %b required 0", busy_a); end
        n_checks++; if (xd_b !== '0)   begin n_errors++; $display("FAIL reset xd_b got %h required 0", xd_b); end
        n_checks++; if (done_b !== 1'b0 || busy_b !== 1'b0) begin n_errors++; $display("FAIL reset b flags got done=%b busy=%b required 0", done_b, busy_b); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_ones();
        int cyc;
        for (int g = 0; g < 16; g++) xa[g] = 16'h3C00;
        for (int h = 0; h < 4; h++)  da[h] = 16'h4000;
        pack_a();
        run_a(cyc);
        n_checks++; if (cyc != 13) begin n_errors++; $display("FAIL ones latency got %0d required 13", cyc); end
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL ones busy_after_done got %b required 0", busy_a); end
        for (int g = 0; g < 16; g++) begin
            n_checks++;
            if (xd_a[g*16 +: 16] !== 16'h4000) begin
                n_errors++; $display("FAIL ones elem %0d got %h required 4000", g, xd_a[g*16 +: 16]);
            end
        end
    endtask

    task automatic test_per_head();
        int cyc;
        logic [15:0] want [4];
        want[0] = 16'h4200; want[1] = 16'hBE00; want[2] = 16'h0000; want[3] = 16'h4A00;
        for (int g = 0; g < 16; g++) xa[g] = 16'h4200;
        da[0] = 16'h3C00; da[1] = 16'hB800; da[2] = 16'h0000; da[3] = 16'h4400;
        pack_a();
        run_a(cyc);
        n_checks++; if (cyc != 13) begin n_errors++; $display("FAIL per_head latency got %0d required 13", cyc); end
        for (int g = 0; g < 16; g++) begin
            n_checks++;
            if (xd_a[g*16 +: 16] !== want[g/4]) begin
                n_errors++; $display("FAIL per_head elem %0d got %h required %h", g, xd_a[g*16 +: 16], want[g/4]);
            end
        end
    endtask

    task automatic test_random_big();
        int cyc;
        logic [15:0] exp_v;
        for (int it = 0; it < 4; it++) begin
            for (int g = 0; g < 30; g++) xb[g] = rand_f16();
            for (int h = 0; h < 5; h++)  db[h] = rand_f16();
            pack_b();
            run_b(cyc);
            n_checks++; if (cyc != 27) begin n_errors++; $display("FAIL random_big latency run %0d got %0d required 27", it, cyc); end
            for (int g = 0; g < 30; g++) begin
                exp_v = ref_mul(db[(g / 3) % 5], xb[g]);
                n_checks++;
                if (xd_b[g*16 +: 16] !== exp_v) begin
                    n_errors++; $display("FAIL random_big run %0d elem %0d x=%h d=%h got %h required %h",
                                         it, g, xb[g], db[(g / 3) % 5], xd_b[g*16 +: 16], exp_v);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int rises = 0;
        int first = 0;
        int cyc;
        logic prev = 1'b0;
        logic [15:0] exp_v;
        for (int g = 0; g < 16; g++) xa[g] = rand_f16();
        for (int h = 0; h < 4; h++)  da[h] = rand_f16();
        pack_a();
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (done_a === 1'b1 && prev === 1'b0) begin rises++; if (first == 0) first = c; end
            prev = done_a;
            @(negedge clk); start_a = (c == 3 || c == 7 || c == 12);
            @(posedge clk); #1; start_a = 1'b0;
        end
        n_checks++; if (first != 13) begin n_errors++; $display("FAIL busy_start latency got %0d required 13", first); end
        n_checks++; if (rises != 1)  begin n_errors++; $display("FAIL busy_start done_rises got %0d required 1", rises); end
        n_checks++; if (done_a !== 1'b1) begin n_errors++; $display("FAIL busy_start done_held got %b required 1", done_a); end
        for (int g = 0; g < 16; g++) begin
            exp_v = ref_mul(da[g / 4], xa[g]);
            n_checks++;
            if (xd_a[g*16 +: 16] !== exp_v) begin
                n_errors++; $display("FAIL busy_start elem %0d got %h required %h", g, xd_a[g*16 +: 16], exp_v);
            end
        end
        // A start from IDLE is accepted and clears done on that edge.
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            n_errors++; $display("FAIL busy_start restart got done=%b busy=%b required done=0 busy=1", done_a, busy_a);
        end
        cyc = 1;
        while (done_a !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (cyc != 13) begin n_errors++; $display("FAIL busy_start second_latency got %0d required 13", cyc); end
    endtask

    task automatic test_rst_mid_run();
        int cyc;
        logic stale = 1'b0;
        logic [15:0] exp_v;
        for (int g = 0; g < 16; g++) xa[g] = rand_f16();
        for (int h = 0; h < 4; h++)  da[h] = rand_f16();
        xa[0] = 16'h3C00; da[0] = 16'h3C00;
        pack_a();
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; #1;
        n_checks++; if (xd_a !== '0) begin n_errors++; $display("FAIL rst_mid xd_a got %h required 0", xd_a); end
        n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_errors++; $display("FAIL rst_mid flags got done=%b busy=%b required 0", done_a, busy_a);
        end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (xd_a !== '0 || busy_a !== 1'b0) stale = 1'b1;
        end
        n_checks++; if (stale !== 1'b0) begin n_errors++; $display("FAIL rst_mid stale_write got %b required 0", stale); end
        run_a(cyc);
        n_checks++; if (cyc != 13) begin n_errors++; $display("FAIL rst_mid rerun_latency got %0d required 13", cyc); end
        for (int g = 0; g < 16; g++) begin
            exp_v = ref_mul(da[g / 4], xa[g]);
            n_checks++;
            if (xd_a[g*16 +: 16] !== exp_v) begin
                n_errors++; $display("FAIL rst_mid elem %0d got %h required %h", g, xd_a[g*16 +: 16], exp_v);
            end
        end
    endtask

    // Residual adder stand-in: start2 = done, start1 raised a cycle later.
    task automatic test_residual();
        int cyc;
        logic start1;
        logic [15:0] y_in, y_out, exp_v;
        for (int g = 0; g < 16; g++) xa[g] = rand_f16();
        for (int h = 0; h < 4; h++)  da[h] = rand_f16();
        pack_a();
        run_a(cyc);
        @(posedge clk); #1; start1 = 1'b1;
        n_checks++; if ((start1 & done_a) !== 1'b1) begin
            n_errors++; $display("FAIL residual handshake got start2=%b required 1", done_a);
        end
        for (int g = 0; g < 16; g++) begin
            y_in = 16'($urandom) & 16'h7FFF;
            if (y_in[14:10] == 5'h0 || y_in[14:10] == 5'h1F) y_in[14:10] = 5'd15;
            y_out = ref_add(y_in, xd_a[g*16 +: 16]);
            exp_v = ref_add(y_in, ref_mul(da[g / 4], xa[g]));
            n_checks++;
            if (y_out !== exp_v) begin
                n_errors++; $display("FAIL residual elem %0d got %h required %h", g, y_out, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_per_head();
        test_random_big();
        test_start_while_busy();
        test_rst_mid_run();
        test_residual();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
